// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard logic.
// haz_entry_t carries one in-flight instruction's destination info through the shadow pipeline.
package mips_pipe_pkg;

  localparam int ADDR_W_DEF = 5;
  // Upper bound on ADDR_W; narrower addresses are zero-extended into entries.
  localparam int ADDR_W_MAX = 8;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] rd;
    logic                  wr;
    logic                  ld;
  } haz_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Priority encoder: selects the youngest tracked stage (k>=1) whose destination matches src_i.
// Combinational; loads in stages younger than LOAD_READY cannot supply data and are skipped.
module fwd_match
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  haz_entry_t [DEPTH-1:1] stage_i,
  input  logic [ADDR_W-1:0]      src_i,
  input  logic                   src_vld_i,
  output logic [SEL_W-1:0]       sel_o
);

  logic [ADDR_W_MAX-1:0] src_ext;

  assign src_ext = ADDR_W_MAX'(src_i);

  // Scan oldest to youngest so the lowest matching index is the one left in sel_o.
  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (src_vld_i && stage_i[k].valid && stage_i[k].wr && (stage_i[k].rd != '0) &&
          (stage_i[k].rd == src_ext) && !(stage_i[k].ld && (k < LOAD_READY))) begin
        sel_o = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit: a shadow pipeline of in-flight destinations drives EX operand
// selects and the ID stall, 0-cycle combinational outputs. Defining HAZ_PERF_EN adds stall_cnt/fwd_cnt.
module fwd_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              stall_ext,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall_id
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  haz_entry_t [DEPTH-1:0] stage_q, stage_d;
  logic [ADDR_W-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
  logic                   rs1_used_q, rs1_used_d, rs2_used_q, rs2_used_d;
  logic [ADDR_W_MAX-1:0]  id_rs1_ext, id_rs2_ext;
  logic                   ld_hit;

  assign id_rs1_ext = ADDR_W_MAX'(id_rs1);
  assign id_rs2_ext = ADDR_W_MAX'(id_rs2);

  // Loads still short of LOAD_READY cannot forward yet, so a dependent ID instruction must wait.
  always_comb begin
    ld_hit = 1'b0;
    for (int j = 0; j < LOAD_READY-1; j++) begin
      if (stage_q[j].valid && stage_q[j].ld && stage_q[j].wr && (stage_q[j].rd != '0) &&
          ((id_rs1_used && (stage_q[j].rd == id_rs1_ext)) ||
           (id_rs2_used && (stage_q[j].rd == id_rs2_ext)))) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign stall_id = id_valid && !flush && ld_hit;

  always_comb begin
    stage_d    = stage_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_used_d = rs1_used_q;
    rs2_used_d = rs2_used_q;
    if (!stall_ext) begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        stage_d[i] = stage_q[i-1];
      end
      stage_d[0] = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rs1_used_d = 1'b0;
      rs2_used_d = 1'b0;
      if (id_valid && !stall_id && !flush) begin
        stage_d[0].valid = 1'b1;
        stage_d[0].rd    = ADDR_W_MAX'(id_rd);
        stage_d[0].wr    = id_reg_write;
        stage_d[0].ld    = id_mem_read;
        rs1_d            = id_rs1;
        rs2_d            = id_rs2;
        rs1_used_d       = id_rs1_used;
        rs2_used_d       = id_rs2_used;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_used_q <= rs1_used_d;
      rs2_used_q <= rs2_used_d;
    end
  end

  fwd_match #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LOAD_READY(LOAD_READY),
    .SEL_W     (SEL_W)
  ) u_match_a (
    .stage_i  (stage_q[DEPTH-1:1]),
    .src_i    (rs1_q),
    .src_vld_i(stage_q[0].valid && rs1_used_q),
    .sel_o    (fwd_a)
  );

  fwd_match #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LOAD_READY(LOAD_READY),
    .SEL_W     (SEL_W)
  ) u_match_b (
    .stage_i  (stage_q[DEPTH-1:1]),
    .src_i    (rs2_q),
    .src_vld_i(stage_q[0].valid && rs2_used_q),
    .sel_o    (fwd_b)
  );

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!stall_ext) begin
      if (stall_id) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((fwd_a != '0) || (fwd_b != '0)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default DEPTH=3/LOAD_READY=2 instance plus a DEPTH=5/LOAD_READY=3
// instance sharing the same ID-side stimulus.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic       stall_ext, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_id;
  logic [2:0] fwd5_a, fwd5_b;
  logic       stall5_id;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt3, fwd_cnt3, stall_cnt5, fwd_cnt5;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .stall_ext(stall_ext),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_id(stall_id)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
`endif
  );

  fwd_hazard_unit #(.DEPTH(5), .LOAD_READY(3)) u_dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .stall_ext(stall_ext),
    .flush(flush), .fwd_a(fwd5_a), .fwd_b(fwd5_b), .stall_id(stall5_id)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt5), .fwd_cnt(fwd_cnt5)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
  endtask

  task automatic op_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
  endtask

  task automatic op_lw(input logic [4:0] rd, input logic [4:0] base);
    set_id(1'b1, base, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
  endtask

  task automatic id_bub();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    id_bub();
    repeat (n) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    stall_ext = 1'b0;
    flush     = 1'b0;
    id_bub();
    #2;
    check_val("rst_fwd_a", 32'(fwd_a), 0);
    check_val("rst_fwd_b", 32'(fwd_b), 0);
    check_val("rst_stall", 32'(stall_id), 0);
    check_val("rst5_fwd_a", 32'(fwd5_a), 0);
    check_val("rst5_stall", 32'(stall5_id), 0);
    tick();
    tick();
    reset = 1'b1;

    // add r3,r1,r2 ; add r4,r3,r1
    op_alu(5'd3, 5'd1, 5'd2); #1;
    check_val("s1_first_stall", 32'(stall_id), 0);
    tick();
    op_alu(5'd4, 5'd3, 5'd1); #1;
    check_val("s1_dep_stall", 32'(stall_id), 0);
    tick();
    id_bub(); #1;
    check_val("s1_fwd_a", 32'(fwd_a), 1);
    check_val("s1_fwd_b", 32'(fwd_b), 0);
    drain(6);

    // lw r5,0(r1) ; add r6,r5,r5
    op_lw(5'd5, 5'd1); tick();
    op_alu(5'd6, 5'd5, 5'd5); #1;
    check_val("s2_stall", 32'(stall_id), 1);
    tick();
    check_val("s2_stall_done", 32'(stall_id), 0);
    check_val("s2_bubble_fwd_a", 32'(fwd_a), 0);
    tick();
    id_bub(); #1;
    check_val("s2_fwd_a", 32'(fwd_a), 2);
    check_val("s2_fwd_b", 32'(fwd_b), 2);
    drain(6);

    // writes to r0 never forward or stall
    op_alu(5'd0, 5'd1, 5'd2); tick();
    op_alu(5'd4, 5'd0, 5'd0); #1;
    check_val("s3_stall", 32'(stall_id), 0);
    tick();
    id_bub(); #1;
    check_val("s3_fwd_a", 32'(fwd_a), 0);
    check_val("s3_fwd_b", 32'(fwd_b), 0);
    op_lw(5'd0, 5'd1); tick();
    op_alu(5'd4, 5'd0, 5'd0); #1;
    check_val("s3_lw_r0_stall", 32'(stall_id), 0);
    drain(6);

    // youngest producer wins
    op_alu(5'd7, 5'd1, 5'd2); tick();
    op_alu(5'd7, 5'd2, 5'd3); tick();
    op_alu(5'd8, 5'd7, 5'd1); tick();
    id_bub(); #1;
    check_val("s4_fwd_a", 32'(fwd_a), 1);
    check_val("s4_fwd_b", 32'(fwd_b), 0);
    drain(6);

    // load-use stall held by stall_ext for 3 cycles
    op_alu(5'd1, 5'd2, 5'd3); tick();
    op_lw(5'd5, 5'd1); tick();
    op_alu(5'd6, 5'd5, 5'd5); #1;
    check_val("s5_stall", 32'(stall_id), 1);
    check_val("s5_lw_fwd_a", 32'(fwd_a), 1);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("s5_frz_stall", 32'(stall_id), 1);
      check_val("s5_frz_fwd_a", 32'(fwd_a), 1);
    end
    stall_ext = 1'b0; #1;
    check_val("s5_rel_stall", 32'(stall_id), 1);
    tick();
    check_val("s5_after_stall", 32'(stall_id), 0);
    check_val("s5_bubble_fwd_a", 32'(fwd_a), 0);
    tick();
    id_bub(); #1;
    check_val("s5_fwd_a", 32'(fwd_a), 2);
    check_val("s5_fwd_b", 32'(fwd_b), 2);
    drain(6);

    // flush kills the ID instruction and suppresses the stall
    op_lw(5'd5, 5'd1); tick();
    op_alu(5'd9, 5'd5, 5'd5); flush = 1'b1; #1;
    check_val("s5_flush_stall", 32'(stall_id), 0);
    tick();
    flush = 1'b0;
    op_alu(5'd12, 5'd9, 5'd5); #1;
    check_val("s5_post_flush_stall", 32'(stall_id), 0);
    tick();
    id_bub(); #1;
    check_val("s5_flush_fwd_a", 32'(fwd_a), 0);
    check_val("s5_flush_fwd_b", 32'(fwd_b), 2);
    drain(6);

    // asynchronous reset mid-stream
    op_alu(5'd3, 5'd1, 5'd2); tick();
    op_lw(5'd5, 5'd3); tick();
    op_alu(5'd6, 5'd5, 5'd1); #1;
    check_val("s6_pre_fwd_a", 32'(fwd_a), 1);
    check_val("s6_pre_stall", 32'(stall_id), 1);
    #2 reset = 1'b0; #1;
    check_val("s6_rst_fwd_a", 32'(fwd_a), 0);
    check_val("s6_rst_stall", 32'(stall_id), 0);
    check_val("s6_rst5_fwd_a", 32'(fwd5_a), 0);
    id_bub(); #1;
    reset = 1'b1;
    tick();
    op_alu(5'd3, 5'd1, 5'd2); tick();
    op_alu(5'd4, 5'd3, 5'd1); tick();
    id_bub(); #1;
    check_val("s6_fwd_a", 32'(fwd_a), 1);
    drain(6);

    // DEPTH=5, LOAD_READY=3: 2-cycle load-use stall, then forward from stage 3
    op_lw(5'd5, 5'd1); tick();
    op_alu(5'd6, 5'd5, 5'd5); #1;
    check_val("d5_stall_c1", 32'(stall5_id), 1);
    tick();
    check_val("d5_stall_c2", 32'(stall5_id), 1);
    tick();
    check_val("d5_stall_c3", 32'(stall5_id), 0);
    tick();
    id_bub(); #1;
    check_val("d5_fwd_a", 32'(fwd5_a), 3);
    check_val("d5_fwd_b", 32'(fwd5_b), 3);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
